if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction fetch stage of the pipelined core. It sits directly upstream of the instruction decode stage.
- Fetches 32-bit words from instruction memory over a req/gnt/rvalid interface.
- Buffers fetched words with their PCs in a small FIFO.
- Presents the oldest word to decode through the valid/notify handshake.
- Redirects fetch and flushes all in-flight work on a branch/jump from the execute stage.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
DEPTH, 2, fetch buffer entries; power of two, minimum 2.

Ports:
clk  input  1  clock, rising edge
resetn_i  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address, word-aligned
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid
imem_rdata_i  input  32  response instruction word
valid_o  output  1  buffer head valid for decode
instr_o  output  32  head instruction
pc_o  output  32  head PC
notify_i  input  1  decode consumed the head (sampled at rising edge)
branch_i  input  1  redirect request from execute
branch_target_i  input  32  redirect PC; bits [1:0] ignored (treated as 0)

Behaviour:
Clock and reset
- One clock (clk). Reset resetn_i is asynchronous, active-low.
- Reset values: fetch_pc = BOOT_ADDR; FIFO empty; state = REQ after release.
- Outputs during reset: imem_req_o = 0, imem_addr_o = BOOT_ADDR, valid_o = 0, instr_o = 0, pc_o = 0.
- Reset asserted mid-transaction aborts everything. Any response arriving after reset release while no request is outstanding is ignored.

Buffer and output
- DEPTH-entry FIFO of {pc, instr}.
- valid_o = FIFO not empty. instr_o/pc_o show the head combinationally; both are 0 when empty.
- Head is popped at a rising edge where notify_i = 1 and valid_o = 1. notify_i while empty is ignored.
- At most one memory transaction is outstanding at any time.
- A new request is issued only if free entries > (1 if a response is pending, else 0). A response therefore never finds the FIFO full.
- A pop and a push in the same cycle are both performed; occupancy is unchanged.

FSM states
- IDLE: no room in the FIFO.
  - imem_req_o = 0.
  - Goes to REQ when room becomes available.
- REQ: imem_req_o = 1, imem_addr_o = fetch_pc.
  - On gnt: go to WAIT, fetch_pc += 4.
  - imem_addr_o may change while ungranted (branch only); memory samples the address on gnt.
- WAIT: awaiting rvalid; imem_req_o = 0.
  - On rvalid: push {issued_pc, rdata}.
  - Then go to REQ if room remains after the push/pop, else IDLE.
- DROP: awaiting rvalid of a cancelled transaction.
  - The response is discarded, then go to REQ.
- Latency: rvalid arrives no earlier than the cycle after gnt. Minimum latency from request to valid_o is 2 cycles (gnt cycle, rvalid cycle, visible next cycle).
- Throughput: one word per 2 cycles (no pipelining of requests).

Branch/redirect (branch_i = 1 at a rising edge)
- Effects at that edge:
  - FIFO flushed.
  - fetch_pc = {branch_target_i[31:2], 2'b00}.
  - Any simultaneous notify_i pop and rvalid push are discarded (branch wins).
- State afterwards, by state at the edge:
  - IDLE or REQ without gnt: go to REQ with the target address.
  - REQ with gnt in the same cycle: go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: response discarded, go to REQ.
  - DROP: stay in DROP until rvalid, with the new target.
- Branch during DROP followed by another branch: the last target wins.
- fetch_pc wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Unexpected rvalid in IDLE or REQ is ignored.

Test Plan:
- Reset release, memory grants immediately, rvalid next cycle, notify_i held 1 → valid_o pulses with pc_o = 0x0, 0x4, 0x8…, instr_o equal to memory contents at those addresses, one word every 2 cycles.
- notify_i held 0, DEPTH = 2 → exactly 2 words buffered, FSM in IDLE, imem_req_o = 0. Single notify_i pulse → one pop, one new request to 0x8.
- Branch to 0x100 while in WAIT, rvalid 3 cycles later carrying word@0x4 → response dropped, FIFO empty. Next request address = 0x100. First valid_o shows pc_o = 0x100.
- Branch to 0x203 in the same cycle as gnt for 0x10 → DROP entered, 0x10 data discarded, next request to 0x200.
- Branch coinciding with notify_i and rvalid while FIFO holds 1 entry → FIFO empty next cycle, valid_o = 0, no stale PC ever presented.
- Reset asserted while in WAIT, then released; late rvalid arrives → ignored. Fetch restarts at BOOT_ADDR; valid_o = 0 until the first new response.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage: instruction fetch stage, directly upstream of decode.
//
// Fetches 32-bit words over a req/gnt/rvalid memory interface with at most one
// transaction outstanding. Fetched words are buffered with their PCs in a
// DEPTH-entry FIFO whose head is presented to decode. A branch from execute
// flushes the FIFO, redirects the fetch PC and cancels any in-flight access.
//
// Ports:
//   clk              clock, rising edge
//   resetn_i         asynchronous active-low reset
//   imem_req_o       fetch request (held until granted)
//   imem_addr_o      fetch address, word-aligned
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    response data valid
//   imem_rdata_i     response instruction word
//   valid_o          FIFO head valid for decode
//   instr_o          head instruction (0 when empty)
//   pc_o             head PC (0 when empty)
//   notify_i         decode consumed the head this cycle
//   branch_i         redirect request from execute
//   branch_target_i  redirect PC, bits [1:0] ignored
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        resetn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        notify_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } state_t;

    state_t            r_state;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       r_issued_pc;

    logic [31:0]       r_pc_mem    [DEPTH];
    logic [31:0]       r_instr_mem [DEPTH];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;

    logic              w_pop;
    logic              w_push;
    logic [CntW-1:0]   w_count_after;
    logic [31:0]       w_target;

    // A branch discards both the pop and the push of its cycle.
    always_comb begin
        w_target      = {branch_target_i[31:2], 2'b00};
        w_pop         = notify_i & (r_count != '0) & ~branch_i;
        w_push        = (r_state == StWait) & imem_rvalid_i & ~branch_i;
        w_count_after = r_count + CntW'(w_push) - CntW'(w_pop);
    end

    // Fetch FSM. Requests are only issued with no transaction outstanding, so
    // room in REQ guarantees the eventual response finds a free entry.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state     <= StReq;
            r_fetch_pc  <= BOOT_ADDR;
            r_issued_pc <= BOOT_ADDR;
        end else if (branch_i) begin
            r_fetch_pc <= w_target;
            unique case (r_state)
                StIdle:  r_state <= StReq;
                StReq:   r_state <= imem_gnt_i    ? StDrop : StReq;
                StWait:  r_state <= imem_rvalid_i ? StReq  : StDrop;
                StDrop:  r_state <= imem_rvalid_i ? StReq  : StDrop;
                default: r_state <= StReq;
            endcase
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_count_after != Full) begin
                        r_state <= StReq;
                    end
                end
                StReq: begin
                    if (imem_gnt_i) begin
                        r_state     <= StWait;
                        r_issued_pc <= r_fetch_pc;
                        r_fetch_pc  <= r_fetch_pc + 32'd4;
                    end
                end
                StWait: begin
                    if (imem_rvalid_i) begin
                        r_state <= (w_count_after != Full) ? StReq : StIdle;
                    end
                end
                StDrop: begin
                    // Response of a cancelled access: discard it.
                    if (imem_rvalid_i) begin
                        r_state <= StReq;
                    end
                end
                default: r_state <= StReq;
            endcase
        end
    end

    // Fetch buffer; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            r_pc_mem    <= '{default: '0};
            r_instr_mem <= '{default: '0};
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else if (branch_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wptr]    <= r_issued_pc;
                r_instr_mem[r_wptr] <= imem_rdata_i;
                r_wptr              <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            r_count <= w_count_after;
        end
    end

    // Request is masked during reset since the state already sits in REQ.
    always_comb begin
        imem_req_o  = resetn_i & (r_state == StReq);
        imem_addr_o = r_fetch_pc;
        valid_o     = (r_count != '0);
        instr_o     = valid_o ? r_instr_mem[r_rptr] : 32'h0;
        pc_o        = valid_o ? r_pc_mem[r_rptr]    : 32'h0;
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage: randomized self-checking bench for if_stage.
//
// A memory responder answers granted requests after a random latency. A
// transaction-level model (queue of {pc, instr}, fetch PC, pending-access
// status) predicts the outputs, which are compared every cycle on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] BootAddr = 32'h0000_0000;
    localparam int unsigned Depth    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        notify;
    logic        branch;
    logic [31:0] branch_target;

    always #5 clk = ~clk;

    if_stage #(
        .BOOT_ADDR (BootAddr),
        .DEPTH     (Depth)
    ) u_dut (
        .clk             (clk),
        .resetn_i        (resetn),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .valid_o         (valid),
        .instr_o         (instr),
        .pc_o            (pc),
        .notify_i        (notify),
        .branch_i        (branch),
        .branch_target_i (branch_target)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: pending 0 = none, 1 = live access, 2 = cancelled access.
    ent_t        m_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_issued;
    int          m_pend;

    // Memory responder state.
    bit          mem_out;
    bit          mem_stale;
    int          mem_lat;
    logic [31:0] mem_addr;

    // Stimulus knobs, in percent.
    int p_gnt, p_notify, p_branch, p_spur, max_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = BootAddr;
        m_issued   = BootAddr;
        m_pend     = 0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        if (pct(25)) t = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        else         t = $urandom & 32'h0000_FFFF;
        return t;
    endfunction

    task automatic run_cycle();
        bit          req_exp;
        bit          resp;
        bit          grant;
        bit          dut_req;
        bit          sched;
        logic [31:0] dut_addr;
        ent_t        e;

        @(negedge clk);
        req_exp = (m_pend == 0) && (m_q.size() < Depth);
        check_eq("req", 32'(imem_req), 32'(req_exp));
        if (req_exp) check_eq("addr", imem_addr, m_fetch_pc);
        check_eq("valid", 32'(valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_eq("pc", pc, m_q[0].pc);
            check_eq("instr", instr, m_q[0].instr);
        end else begin
            check_eq("pc_empty", pc, 32'h0);
            check_eq("instr_empty", instr, 32'h0);
        end

        // Drive this cycle's inputs.
        imem_gnt = pct(p_gnt) && !mem_stale;
        sched    = mem_out && (mem_lat == 0);
        if (sched) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_stale ? $urandom : mem_word(mem_addr);
        end else if (!mem_out && pct(p_spur)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        notify        = pct(p_notify);
        branch        = pct(p_branch);
        branch_target = pick_target();
        dut_req       = imem_req;
        dut_addr      = imem_addr;

        // Model update for the coming rising edge.
        resp  = imem_rvalid && (m_pend != 0);
        grant = req_exp && imem_gnt;
        if (branch) begin
            m_q.delete();
            m_fetch_pc = {branch_target[31:2], 2'b00};
            if (grant)            m_pend = 2;
            else if (resp)        m_pend = 0;
            else if (m_pend != 0) m_pend = 2;
        end else begin
            if (notify && m_q.size() != 0) void'(m_q.pop_front());
            if (resp) begin
                if (m_pend == 1) begin
                    e.pc    = m_issued;
                    e.instr = mem_word(m_issued);
                    m_q.push_back(e);
                end
                m_pend = 0;
            end
            if (grant) begin
                m_issued   = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_pend     = 1;
            end
        end

        // Memory responder update.
        if (sched) begin
            mem_out   = 1'b0;
            mem_stale = 1'b0;
        end else if (mem_out && mem_lat > 0) begin
            mem_lat--;
        end
        if (dut_req && imem_gnt) begin
            mem_out  = 1'b1;
            mem_addr = dut_addr;
            mem_lat  = $urandom_range(max_lat, 0);
        end
        @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   32'(imem_req), 32'h0);
        check_eq({tag, "_addr"},  imem_addr, BootAddr);
        check_eq({tag, "_valid"}, 32'(valid), 32'h0);
        check_eq({tag, "_instr"}, instr, 32'h0);
        check_eq({tag, "_pc"},    pc, 32'h0);
    endtask

    // Asynchronous reset in mid-cycle; an access still in flight is answered
    // after release, with grants held off so it cannot alias a new request.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        resetn      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        notify      = 1'b0;
        branch      = 1'b0;
        #1;
        check_reset_outputs("rst_assert");
        repeat (cycles) @(negedge clk);
        check_reset_outputs("rst_hold");
        model_reset();
        if (mem_out) mem_stale = 1'b1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn        = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        notify        = 1'b0;
        branch        = 1'b0;
        branch_target = 32'h0;
        mem_out       = 1'b0;
        mem_stale     = 1'b0;
        mem_lat       = 0;
        mem_addr      = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        resetn = 1'b1;

        // Streaming: immediate grant, next-cycle response, decode always ready.
        p_gnt = 100; p_notify = 100; p_branch = 0; p_spur = 0; max_lat = 0;
        repeat (40) run_cycle();

        // Decode stalled: buffer fills and requests stop.
        p_notify = 0;
        repeat (20) run_cycle();
        p_notify = 100;
        repeat (10) run_cycle();

        // Randomized traffic with branches, stalls, spurious responses and resets.
        p_gnt = 60; p_notify = 50; p_branch = 8; p_spur = 10; max_lat = 3;
        for (int r = 0; r < 4; r++) begin
            repeat (700) run_cycle();
            for (int k = 0; k < 20 && !mem_out; k++) run_cycle();
            do_reset(2);
        end

        // Heavier branching with short latency.
        p_gnt = 80; p_notify = 70; p_branch = 25; max_lat = 1;
        repeat (800) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
